// File: rtl/maze_job_arbiter.sv
// Round-robin arbiter sharing one MAZE solver between two clients: forwards the
// owner's maze bit stream, guards the solve with a watchdog and returns path steps.
module maze_job_arbiter #(
  parameter int MAZE_BITS = 289,
  parameter int TIMEOUT   = 1023,
  parameter int CNT_W     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       in_valid0,
  input  logic       in_valid1,
  input  logic       in0,
  input  logic       in1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       solver_in_valid,
  output logic       solver_in,
  input  logic       solver_out_valid,
  input  logic [1:0] solver_out,
  output logic       out_valid0,
  output logic       out_valid1,
  output logic [1:0] out0,
  output logic [1:0] out1,
  output logic       done0,
  output logic       done1,
  output logic [1:0] status,
  output logic [8:0] path_len
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_LOAD  = 3'd2,
    S_SOLVE = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] BITS_MAX  = CNT_W'(MAZE_BITS);
  localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(MAZE_BITS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [8:0]       LEN_MAX   = 9'h1FF;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             lp_q, lp_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             short_q, short_d;
  logic [1:0]       status_q, status_d;
  logic [8:0]       path_len_q, path_len_d;

  logic             gnt0_q, gnt1_q, siv_q, si_q;
  logic             ov0_q, ov1_q, done0_q, done1_q;
  logic [1:0]       o0_q, o1_q;

  logic             own_in_valid_s, own_in_s, fwd_in_s, fwd_out_s, gnt_act_s;

  assign own_in_valid_s = owner_q ? in_valid1 : in_valid0;
  assign own_in_s       = owner_q ? in1 : in0;
  assign fwd_in_s       = own_in_valid_s && (bitcnt_q < BITS_MAX) &&
                          ((state_q == S_GRANT) || (state_q == S_LOAD));
  assign fwd_out_s      = solver_out_valid && ((state_q == S_SOLVE) || (state_q == S_DRAIN));
  assign gnt_act_s      = (state_d == S_GRANT) || (state_d == S_LOAD) ||
                          (state_d == S_SOLVE) || (state_d == S_DRAIN);

  // Job sequencing: arbitration, bit counting, watchdog and status capture
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lp_d     = lp_q;
    bitcnt_d = bitcnt_q;
    wd_d     = wd_q;
    short_d  = short_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d  = S_GRANT;
          // on a tie the client that was not served last wins
          owner_d  = (req0 && req1) ? ~lp_q : req1;
          bitcnt_d = '0;
          short_d  = 1'b0;
          status_d = 2'b00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (own_in_valid_s) begin
          state_d  = S_LOAD;
          bitcnt_d = CNT_W'(1);
        end else begin
          state_d = S_GRANT;
        end
      end
      S_LOAD: begin
        if (own_in_valid_s) begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
          if (bitcnt_q == BITS_LAST) begin
            state_d = S_SOLVE;
            wd_d    = '0;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          short_d = 1'b1;
          state_d = S_SOLVE;
          wd_d    = '0;
        end
      end
      S_SOLVE: begin
        wd_d = wd_q + CNT_W'(1);
        if (solver_out_valid) begin
          state_d = S_DRAIN;
        end else if (wd_q == TMO_LAST) begin
          state_d  = S_DONE;
          status_d = {1'b1, short_q};
        end else begin
          state_d = S_SOLVE;
        end
      end
      S_DRAIN: begin
        if (!solver_out_valid) begin
          state_d  = S_DONE;
          status_d = {1'b0, short_q};
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        lp_d    = owner_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Saturating count of steps forwarded to the owner, cleared at grant
  always_comb begin
    path_len_d = path_len_q;
    if ((state_q == S_IDLE) && (state_d == S_GRANT)) begin
      path_len_d = 9'd0;
    end else if (fwd_out_s && (path_len_q != LEN_MAX)) begin
      path_len_d = path_len_q + 9'd1;
    end else begin
      path_len_d = path_len_q;
    end
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      lp_q       <= 1'b1;
      bitcnt_q   <= '0;
      wd_q       <= '0;
      short_q    <= 1'b0;
      status_q   <= 2'b00;
      path_len_q <= 9'd0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      siv_q      <= 1'b0;
      si_q       <= 1'b0;
      ov0_q      <= 1'b0;
      ov1_q      <= 1'b0;
      o0_q       <= 2'b00;
      o1_q       <= 2'b00;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lp_q       <= lp_d;
      bitcnt_q   <= bitcnt_d;
      wd_q       <= wd_d;
      short_q    <= short_d;
      status_q   <= status_d;
      path_len_q <= path_len_d;
      gnt0_q     <= gnt_act_s && !owner_d;
      gnt1_q     <= gnt_act_s && owner_d;
      siv_q      <= fwd_in_s;
      si_q       <= fwd_in_s && own_in_s;
      ov0_q      <= fwd_out_s && !owner_q;
      ov1_q      <= fwd_out_s && owner_q;
      o0_q       <= (fwd_out_s && !owner_q) ? solver_out : 2'b00;
      o1_q       <= (fwd_out_s && owner_q) ? solver_out : 2'b00;
      done0_q    <= (state_d == S_DONE) && !owner_q;
      done1_q    <= (state_d == S_DONE) && owner_q;
    end
  end

  assign gnt0            = gnt0_q;
  assign gnt1            = gnt1_q;
  assign solver_in_valid = siv_q;
  assign solver_in       = si_q;
  assign out_valid0      = ov0_q;
  assign out_valid1      = ov1_q;
  assign out0            = o0_q;
  assign out1            = o1_q;
  assign done0           = done0_q;
  assign done1           = done1_q;
  assign status          = status_q;
  assign path_len        = path_len_q;

endmodule
